mux_scan_pipe: RTL and testbench
================================

Name: mux_scan_pipe

Overview:
- Parametrised, registered N:1 channel multiplexer, successor to the fixed 16:1 combinational mux.
- Supports any channel count and data width.
- Has two modes: manual select, and an auto-scan mode that dwells on each channel for a programmable number of cycles, then advances round-robin.
- Feeds downstream logic that samples multiplexed data together with its channel tag.

Parameters:
- N_CH, 16, number of input channels (>=2; non-power-of-two allowed).
- DW, 8, data width per channel.
- DWELL_W, 8, width of dwell count.
- SEL_W, $clog2(N_CH), channel index width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  pipeline/scan enable; when 0, state holds.
- mode  input  1  0 = manual select, 1 = auto-scan.
- sel  input  SEL_W  manual channel select (used when mode=0).
- dwell  input  DWELL_W  enabled cycles per channel in scan mode, minus 1.
- in_data  input  N_CH*DW  packed channels; channel i = in_data[i*DW +: DW].
- out_data  output  DW  registered selected data.
- out_ch  output  SEL_W  channel index that produced out_data.
- out_valid  output  1  out_data/out_ch updated this cycle.
- wrap  output  1  one-cycle pulse when scan advances from N_CH-1 to 0.

Behaviour:
- Reset (async, rst_n=0): cur_ch=0, cnt=0, out_data=0, out_ch=0, out_valid=0, wrap=0.
- Internal state:
  - cur_ch[SEL_W]: channel register.
  - cnt[DWELL_W]: dwell counter.
- Stage 1, channel register, on each rising edge with en=1:
  - mode=0: if sel<N_CH then cur_ch<=sel, else cur_ch holds (out-of-range ignored). cnt<=0. wrap<=0.
  - mode=1: if cnt>=dwell, then cnt<=0 and cur_ch<=(cur_ch==N_CH-1)?0:cur_ch+1, with wrap<=(cur_ch==N_CH-1). Otherwise cnt<=cnt+1 and wrap<=0.
  - The comparison uses >= so that lowering dwell mid-dwell advances on the next enabled cycle.
- Stage 2, output register, on each rising edge with en=1:
  - out_data<=in_data slice selected by current cur_ch (pre-update value).
  - out_ch<=cur_ch.
  - out_valid<=1.
- en=0:
  - cur_ch, cnt, out_data and out_ch hold.
  - out_valid<=0, wrap<=0.
- Latency:
  - Manual: sel change reaches out_ch/out_data 2 enabled edges later.
  - in_data change on the current channel reaches out_data 1 edge later.
- Scan timing: each channel appears on out_ch for exactly dwell+1 consecutive enabled cycles. dwell=0 gives a new channel every cycle.
- Mode switch 0->1: scan starts from the current cur_ch with cnt=0. It does not restart at channel 0.
- Mode switch 1->0: cur_ch takes sel on the next enabled edge. cnt clears.
- wrap: asserted in the same cycle cur_ch becomes 0 via scan. It is never asserted in manual mode.
- Reset mid-scan: immediate clear of all outputs. Scanning resumes from channel 0 after release.
- All outputs are registers; no combinational path from inputs to outputs.

Test Plan:
- Common setup for all scenarios: N_CH=16, DW=8, channel i data=8'h10+i.
- Reset/manual: hold rst_n=0 → all outputs 0. Release, en=1, mode=0, sel=5 → after 2 edges out_ch=5, out_data=8'h15, out_valid=1. Set sel=12 → 2 edges later out_data=8'h1C.
- Scan dwell=0: mode=1 from cur_ch=0 → out_ch sequence 0,1,...,15,0 on consecutive cycles. wrap is high for exactly 1 cycle, aligned with cur_ch returning to 0.
- Scan dwell=2: each out_ch value is held 3 cycles. Pulse en=0 for 4 cycles mid-dwell → out_valid=0 and out_ch frozen; the dwell resumes with the remaining count intact.
- Boundaries:
  - Manual sel=15 → out_data=8'h1F.
  - Rebuild with N_CH=10, drive sel=12 → cur_ch holds previous value.
  - Scan with N_CH=10 wraps 9→0 with a wrap pulse.
- Dwell shrink/mode switch:
  - In scan with dwell=7 at cnt=5, set dwell=1 → advance on the next edge.
  - Switch mode 1→0 with sel=3 → out_ch=3 after 2 edges.
- Async reset mid-scan: assert rst_n between clock edges → outputs clear immediately (no clock needed). After release, scan restarts at channel 0.

Source files
------------

// File: rtl/mux_scan_pipe.sv
// Registered N:1 channel multiplexer with manual select and round-robin auto-scan.
// Stage 1 holds the channel pointer and dwell counter; stage 2 registers the
// selected data together with the channel tag that produced it.
module mux_scan_pipe #(
    parameter int unsigned N_CH    = 16,
    parameter int unsigned DW      = 8,
    parameter int unsigned DWELL_W = 8,
    parameter int unsigned SEL_W   = $clog2(N_CH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic [DWELL_W-1:0]   dwell,
    input  logic [N_CH*DW-1:0]   in_data,
    output logic [DW-1:0]        out_data,
    output logic [SEL_W-1:0]     out_ch,
    output logic                 out_valid,
    output logic                 wrap
);

    // One extra bit so N_CH itself is representable when it is a power of two.
    localparam int unsigned SEL_XW = SEL_W + 1;
    localparam logic [SEL_XW-1:0] N_CH_EXT = SEL_XW'(N_CH);
    localparam logic [SEL_W-1:0]  LAST_CH  = SEL_W'(N_CH - 1);

    logic [SEL_W-1:0]   cur_ch;
    logic [DWELL_W-1:0] cnt;

    logic [SEL_W-1:0]   cur_ch_nxt;
    logic [DWELL_W-1:0] cnt_nxt;
    logic               wrap_nxt;

    logic [DW-1:0]      out_data_nxt;
    logic [SEL_W-1:0]   out_ch_nxt;
    logic               out_valid_nxt;

    logic [DW-1:0]      sel_data_c;
    logic               sel_ok_c;
    logic               at_last_c;
    logic               dwell_done_c;

    // Select the slice addressed by the current (pre-update) channel pointer.
    always_comb begin
        sel_data_c = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (cur_ch == SEL_W'(i)) begin
                sel_data_c = in_data[i*DW +: DW];
            end
        end
    end

    // Qualifiers: manual select in range, pointer on the last channel, dwell expired.
    always_comb begin
        sel_ok_c     = ({1'b0, sel} < N_CH_EXT);
        at_last_c    = (cur_ch == LAST_CH);
        // >= so that shrinking dwell below the running count advances at once.
        dwell_done_c = (cnt >= dwell);
    end

    // Stage 1 next state: channel pointer, dwell counter, wrap pulse.
    always_comb begin
        cur_ch_nxt = cur_ch;
        cnt_nxt    = cnt;
        wrap_nxt   = 1'b0;
        if (en) begin
            if (!mode) begin
                if (sel_ok_c) begin
                    cur_ch_nxt = sel;
                end
                cnt_nxt = '0;
            end else if (dwell_done_c) begin
                cnt_nxt    = '0;
                cur_ch_nxt = at_last_c ? '0 : cur_ch + SEL_W'(1);
                wrap_nxt   = at_last_c;
            end else begin
                cnt_nxt = cnt + DWELL_W'(1);
            end
        end
    end

    // Stage 2 next state: capture data and tag of the current channel.
    always_comb begin
        out_data_nxt  = out_data;
        out_ch_nxt    = out_ch;
        out_valid_nxt = 1'b0;
        if (en) begin
            out_data_nxt  = sel_data_c;
            out_ch_nxt    = cur_ch;
            out_valid_nxt = 1'b1;
        end
    end

    // Stage 1 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_ch <= '0;
            cnt    <= '0;
            wrap   <= 1'b0;
        end else begin
            cur_ch <= cur_ch_nxt;
            cnt    <= cnt_nxt;
            wrap   <= wrap_nxt;
        end
    end

    // Stage 2 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_data  <= out_data_nxt;
            out_ch    <= out_ch_nxt;
            out_valid <= out_valid_nxt;
        end
    end

endmodule

// File: tb/tb_mux_scan_pipe.sv
// Directed bench for mux_scan_pipe: a 16-channel and a 10-channel instance.
module tb_mux_scan_pipe;

    logic clk = 1'b0;
    logic rst_n;

    // 16-channel instance
    logic         en, mode;
    logic [3:0]   sel;
    logic [7:0]   dwell;
    logic [127:0] in_data;
    logic [7:0]   out_data;
    logic [3:0]   out_ch;
    logic         out_valid, wrap;

    // 10-channel instance
    logic         en10, mode10;
    logic [3:0]   sel10;
    logic [7:0]   dwell10;
    logic [79:0]  in_data10;
    logic [7:0]   out_data10;
    logic [3:0]   out_ch10;
    logic         out_valid10, wrap10;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_scan_pipe #(.N_CH(16), .DW(8), .DWELL_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .dwell(dwell),
        .in_data(in_data), .out_data(out_data), .out_ch(out_ch),
        .out_valid(out_valid), .wrap(wrap)
    );

    mux_scan_pipe #(.N_CH(10), .DW(8), .DWELL_W(8)) dut10 (
        .clk(clk), .rst_n(rst_n), .en(en10), .mode(mode10), .sel(sel10), .dwell(dwell10),
        .in_data(in_data10), .out_data(out_data10), .out_ch(out_ch10),
        .out_valid(out_valid10), .wrap(wrap10)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) in_data[i*8 +: 8] = 8'(8'h10 + i);
        for (int i = 0; i < 10; i++) in_data10[i*8 +: 8] = 8'(8'h10 + i);
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = 4'd0; dwell = 8'd0;
        en10 = 1'b0; mode10 = 1'b0; sel10 = 4'd0; dwell10 = 8'd0;

        // Reset state
        #12;
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_ch", 32'(out_ch), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_wrap", 32'(wrap), 32'h0);

        // Manual select
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1; sel = 4'd5;
        tick(2);
        chk("man5_out_ch", 32'(out_ch), 32'd5);
        chk("man5_out_data", 32'(out_data), 32'h15);
        chk("man5_out_valid", 32'(out_valid), 32'h1);
        sel = 4'd12;
        tick(2);
        chk("man12_out_data", 32'(out_data), 32'h1C);
        chk("man12_out_ch", 32'(out_ch), 32'd12);
        sel = 4'd15;
        tick(2);
        chk("man15_out_data", 32'(out_data), 32'h1F);
        chk("man15_wrap", 32'(wrap), 32'h0);

        // Scan dwell=0 from channel 0: out_ch 0..15,0; wrap with cur_ch -> 0
        sel = 4'd0;
        tick(2);
        chk("pre_scan_out_ch", 32'(out_ch), 32'd0);
        mode = 1'b1; dwell = 8'd0;
        for (int j = 1; j <= 17; j++) begin
            tick(1);
            chk("scan0_out_ch", 32'(out_ch), 32'((j - 1) % 16));
            chk("scan0_wrap", 32'(wrap), 32'(j == 16));
        end

        // Scan dwell=2: cur_ch=1, cnt=0 here; each channel held 3 cycles
        dwell = 8'd2;
        for (int j = 1; j <= 6; j++) begin
            tick(1);
            chk("scan2_out_ch", 32'(out_ch), 32'(1 + (j - 1) / 3));
        end
        tick(1);
        chk("scan2_ch3_first", 32'(out_ch), 32'd3);
        en = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick(1);
            chk("hold_out_valid", 32'(out_valid), 32'h0);
            chk("hold_out_ch", 32'(out_ch), 32'd3);
        end
        en = 1'b1;
        tick(1);
        chk("resume_out_ch_a", 32'(out_ch), 32'd3);
        chk("resume_out_valid", 32'(out_valid), 32'h1);
        tick(1);
        chk("resume_out_ch_b", 32'(out_ch), 32'd3);
        tick(1);
        chk("resume_out_ch_c", 32'(out_ch), 32'd4);

        // Dwell shrink: cur_ch=4, cnt=1; run up to cnt=5 then drop dwell to 1
        dwell = 8'd7;
        tick(4);
        chk("shrink_pre_out_ch", 32'(out_ch), 32'd4);
        dwell = 8'd1;
        tick(1);
        chk("shrink_e1_out_ch", 32'(out_ch), 32'd4);
        tick(1);
        chk("shrink_e2_out_ch", 32'(out_ch), 32'd5);

        // Mode switch 1->0 with sel=3
        mode = 1'b0; sel = 4'd3;
        tick(1);
        chk("sw_e1_out_ch", 32'(out_ch), 32'd5);
        tick(1);
        chk("sw_e2_out_ch", 32'(out_ch), 32'd3);
        chk("sw_e2_out_data", 32'(out_data), 32'h13);

        // Async reset mid-scan, asserted between edges
        mode = 1'b1; dwell = 8'd0;
        tick(3);
        chk("prerst_out_ch", 32'(out_ch), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_ch", 32'(out_ch), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'h0);
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_out_ch0", 32'(out_ch), 32'd0);
        chk("post_rst_out_data0", 32'(out_data), 32'h10);
        tick(1);
        chk("post_rst_out_ch1", 32'(out_ch), 32'd1);

        // N_CH=10: out-of-range select ignored, scan wraps 9 -> 0
        en10 = 1'b1; mode10 = 1'b0; sel10 = 4'd7;
        tick(2);
        chk("n10_man7_out_ch", 32'(out_ch10), 32'd7);
        chk("n10_man7_out_data", 32'(out_data10), 32'h17);
        sel10 = 4'd12;
        tick(2);
        chk("n10_oor_out_ch", 32'(out_ch10), 32'd7);
        chk("n10_oor_out_data", 32'(out_data10), 32'h17);
        sel10 = 4'd8;
        tick(2);
        mode10 = 1'b1; dwell10 = 8'd0;
        tick(1);
        chk("n10_scan_e1_ch", 32'(out_ch10), 32'd8);
        chk("n10_scan_e1_wrap", 32'(wrap10), 32'h0);
        tick(1);
        chk("n10_scan_e2_ch", 32'(out_ch10), 32'd9);
        chk("n10_scan_e2_wrap", 32'(wrap10), 32'h1);
        tick(1);
        chk("n10_scan_e3_ch", 32'(out_ch10), 32'd0);
        chk("n10_scan_e3_wrap", 32'(wrap10), 32'h0);
        chk("n10_scan_e3_data", 32'(out_data10), 32'h10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
